// File: rtl/ps2_pkg.sv
// Shared PS/2 codes, state encodings and frame check helper.
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] BREAK_CODE = 8'hF0;
  localparam logic [BYTE_W-1:0] EXT_CODE   = 8'hE0;
  localparam logic [BYTE_W-1:0] NO_KEY     = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } decode_state_t;

  // Odd parity over data+parity bit and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [BYTE_W-1:0] d,
                                    input logic p,
                                    input logic stop_bit);
    return (^{d, p}) & stop_bit;
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Byte channel from the frame receiver to the scan-code decoder.
interface ps2_keycode_rx_if;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  modport master (output rx_byte, output byte_valid, output frame_err);
  modport slave  (input  rx_byte, input  byte_valid, input  frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM, timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ps2_clk,
  input  logic                  i_ps2_data,
  ps2_keycode_rx_if.master      byte_bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic              clk_s1, clk_s2, clk_prev;
  logic              dat_s1, dat_s2;
  logic              fall;

  frame_state_t      state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0] shift, shift_n;
  logic              par, par_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [BYTE_W-1:0] rx_q, rx_n;
  logic              valid_q, valid_n;
  logic              err_q, err_n;

  // Two-flop synchronizers plus previous-clock flop for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= i_ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= i_ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame state and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
      rx_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      tcnt    <= tcnt_n;
      rx_q    <= rx_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic: bit capture, frame check and inter-edge timeout.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    tcnt_n    = tcnt;
    rx_n      = rx_q;
    valid_n   = 1'b0;
    err_n     = 1'b0;

    if (fall) begin
      tcnt_n = '0;
    end else if (state != IDLE) begin
      tcnt_n = tcnt + TW'(1);
    end

    case (state)
      IDLE: begin
        if (fall && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {dat_s2, shift[BYTE_W-1:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = dat_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (frame_ok(shift, par, dat_s2)) begin
            rx_n    = shift;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled frame is abandoned once the edge gap reaches the limit.
    if (!fall && state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      tcnt_n  = '0;
      err_n   = 1'b1;
    end
  end

  assign byte_bus.rx_byte    = rx_q;
  assign byte_bus.byte_valid = valid_q;
  assign byte_bus.frame_err  = err_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frame reception plus make/break scan-code decode.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ps2_clk,
  input  logic              i_ps2_data,
  output logic [7:0]        o_key,
  output logic              o_key_valid,
  output logic              o_extended,
  output logic              o_frame_err,
  ps2_keycode_rx_if.master  byte_bus
);

  decode_state_t     dstate, dstate_n;
  logic [BYTE_W-1:0] key_n;
  logic              ext_n;
  logic              kv_n;
  logic [BYTE_W-1:0] b;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .byte_bus   (byte_bus)
  );

  assign b           = byte_bus.rx_byte;
  assign o_frame_err = byte_bus.frame_err;

  // Decode state and held-key registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dstate      <= NORMAL;
      o_key       <= NO_KEY;
      o_extended  <= 1'b0;
      o_key_valid <= 1'b0;
    end else begin
      dstate      <= dstate_n;
      o_key       <= key_n;
      o_extended  <= ext_n;
      o_key_valid <= kv_n;
    end
  end

  // Make/break/extended prefix decode; only accepted bytes move the FSM.
  always_comb begin
    dstate_n = dstate;
    key_n    = o_key;
    ext_n    = o_extended;
    kv_n     = 1'b0;

    if (byte_bus.byte_valid) begin
      case (dstate)
        NORMAL: begin
          if (b == BREAK_CODE) begin
            dstate_n = BRK;
          end else if (b == EXT_CODE) begin
            dstate_n = EXT;
          end else begin
            key_n    = b;
            ext_n    = 1'b0;
            kv_n     = 1'b1;
            dstate_n = NORMAL;
          end
        end
        EXT: begin
          dstate_n = NORMAL;
          if (b == BREAK_CODE) begin
            dstate_n = EXT_BRK;
          end else if (b != EXT_CODE) begin
            key_n = b;
            ext_n = 1'b1;
            kv_n  = 1'b1;
          end
        end
        BRK: begin
          dstate_n = NORMAL;
          if (b != EXT_CODE && b != BREAK_CODE && b == o_key && !o_extended) begin
            key_n = NO_KEY;
            ext_n = 1'b0;
          end
        end
        EXT_BRK: begin
          dstate_n = NORMAL;
          if (b != EXT_CODE && b != BREAK_CODE && b == o_key && o_extended) begin
            key_n = NO_KEY;
            ext_n = 1'b0;
          end
        end
        default: dstate_n = NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: makes, breaks, extended keys, errors.
module tb_ps2_keycode_rx;

  localparam int unsigned TO   = 200;
  localparam int unsigned HALF = 10;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic [7:0] o_key;
  logic       o_key_valid;
  logic       o_extended;
  logic       o_frame_err;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int kv0, fe0;

  always #5 i_clk = ~i_clk;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_key       (o_key),
    .o_key_valid (o_key_valid),
    .o_extended  (o_extended),
    .o_frame_err (o_frame_err),
    .byte_bus    (bus)
  );

  // Count every cycle each pulse output is high.
  always @(posedge i_clk) begin
    if (o_key_valid === 1'b1) kv_cnt++;
    if (o_frame_err === 1'b1) fe_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    i_ps2_data = v;
    cycles(HALF);
    i_ps2_clk = 1'b0;
    cycles(HALF);
    i_ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    i_ps2_data = 1'b1;
    cycles(30);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'b1);
    i_ps2_data = 1'b1;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_ps2_clk  = 1'b1;
    i_ps2_data = 1'b1;
    cycles(5);
    i_rst = 1'b0;
    cycles(5);

    check("rst_key",   32'(o_key), 32'h00);
    check("rst_valid", 32'(o_key_valid), 32'h0);
    check("rst_ext",   32'(o_extended), 32'h0);
    check("rst_err",   32'(o_frame_err), 32'h0);

    // Single make 16
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(8'h16, 1'b0);
    check("make16_key",   32'(o_key), 32'h16);
    check("make16_ext",   32'(o_extended), 32'h0);
    check("make16_pulse", 32'(kv_cnt - kv0), 32'd1);

    // Break 16
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);
    check("brk16_key",   32'(o_key), 32'h00);
    check("brk16_pulse", 32'(kv_cnt - kv0), 32'd1);
    check("brk16_noerr", 32'(fe_cnt - fe0), 32'd0);

    // Bad parity frame while 16 held
    send_frame(8'h16, 1'b0);
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1);
    check("par_err",   32'(fe_cnt - fe0), 32'd1);
    check("par_key",   32'(o_key), 32'h16);
    check("par_pulse", 32'(kv_cnt - kv0), 32'd0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);

    // Timeout after 5 data bits, then a good frame
    fe0 = fe_cnt;
    send_partial(5);
    cycles(TO + 100);
    check("tmo_err", 32'(fe_cnt - fe0), 32'd1);
    send_frame(8'h45, 1'b0);
    check("tmo_key",   32'(o_key), 32'h45);
    check("tmo_err2",  32'(fe_cnt - fe0), 32'd1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h45, 1'b0);
    check("rel45_key", 32'(o_key), 32'h00);

    // Extended key, non-extended break must not clear it
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_key", 32'(o_key), 32'h75);
    check("ext_flg", 32'(o_extended), 32'h1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_plainbrk_key", 32'(o_key), 32'h75);
    check("ext_plainbrk_flg", 32'(o_extended), 32'h1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_brk_key", 32'(o_key), 32'h00);
    check("ext_brk_flg", 32'(o_extended), 32'h0);

    // Last pressed wins; older break ignored
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    check("lpw_key", 32'(o_key), 32'h32);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("lpw_oldbrk", 32'(o_key), 32'h32);
    kv0 = kv_cnt;
    send_frame(8'h32, 1'b0);
    send_frame(8'h32, 1'b0);
    check("typematic", 32'(kv_cnt - kv0), 32'd2);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h32, 1'b0);
    check("lpw_rel", 32'(o_key), 32'h00);

    // Stray falling edge with data high is ignored
    fe0 = fe_cnt;
    ps2_bit(1'b1);
    cycles(20);
    send_frame(8'h3A, 1'b0);
    check("stray_key", 32'(o_key), 32'h3A);
    check("stray_err", 32'(fe_cnt - fe0), 32'd0);

    // Reset after 4 data bits, then 2D
    send_partial(4);
    i_rst = 1'b1;
    cycles(3);
    i_rst = 1'b0;
    cycles(3);
    check("mrst_key", 32'(o_key), 32'h00);
    fe0 = fe_cnt;
    send_frame(8'h2D, 1'b0);
    cycles(TO + 50);
    check("mrst_newkey", 32'(o_key), 32'h2D);
    check("mrst_noerr",  32'(fe_cnt - fe0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
